// File: rtl/sdram_wr_pkg.sv
// Shared types for the SDRAM pixel write combiner: FSM states, bus widths, FIFO entry.
package sdram_wr_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_REQ,
    ST_DATA,
    ST_WAIT_DONE
  } state_t;

  // cont marks an entry that directly follows the previous push in the same page
  typedef struct packed {
    logic              cont;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/sync_fifo_scan.sv
// Register-array FIFO with show-ahead head and a second read port that peeks
// the cont flag at an offset from the head, used to size bursts.
module sync_fifo_scan
  import sdram_wr_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  entry_t            push_entry,
  input  logic              pop,
  input  logic [AW:0]       scan_off,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic              scan_cont,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);

  entry_t      mem [2**AW];
  logic [AW:0] wr_ptr, rd_ptr, scan_ptr;
  logic        do_pop;

  assign do_pop   = pop && !empty;
  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign scan_ptr = rd_ptr + scan_off;

  assign head_addr = mem[rd_ptr[AW-1:0]].addr;
  assign head_data = mem[rd_ptr[AW-1:0]].data;
  assign scan_cont = mem[scan_ptr[AW-1:0]].cont;

  // storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  // pointer update; the extra MSB distinguishes full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)        rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/sdram_pixel_write_combiner.sv
// Buffers single-pixel writes and merges runs of consecutive addresses into
// SDRAM bursts of up to BURST_MAX words, never crossing a page.
module sdram_pixel_write_combiner
  import sdram_wr_pkg::*;
#(
  parameter int FIFO_AW   = 4,
  parameter int BURST_MAX = 8,
  parameter int PAGE_AW   = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_data,
  input  logic              flush,
  output logic              idle,
  output logic              m_req,
  input  logic              m_gnt,
  output logic [ADDR_W-1:0] m_addr,
  output logic [FIFO_AW:0]  m_len,
  input  logic              m_data_req,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_done,
  output logic              overflow
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [FIFO_AW:0] BMAX = (FIFO_AW+1)'(BURST_MAX);
  localparam logic [TW-1:0]    TMAX = TW'(TIMEOUT);

  state_t              state, state_nx;
  logic                push_req, wr_en, pop;
  logic                full, empty, scan_cont, scan_grow;
  logic [FIFO_AW:0]    count, scan_len, rem;
  logic [ADDR_W-1:0]   head_addr, last_addr;
  logic [DATA_W-1:0]   head_data;
  logic                have_last, cont_in, flush_pending;
  logic [TW-1:0]       timer;
  entry_t              push_entry;

  // a new handshake opens only while s_ready is low; full FIFO makes it wait
  assign push_req = s_valid && !s_ready;
  assign wr_en    = push_req && !full;

  assign cont_in = have_last && (s_addr == last_addr + ADDR_W'(1)) &&
                   (s_addr[PAGE_AW-1:0] != '0);
  assign push_entry = '{cont: cont_in, addr: s_addr, data: s_data};

  assign idle   = empty && (state == ST_IDLE);
  assign m_data = empty ? '0 : head_data;

  sync_fifo_scan #(.AW(FIFO_AW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (wr_en),
    .push_entry (push_entry),
    .pop        (pop),
    .scan_off   (scan_len),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .scan_cont  (scan_cont),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  // four-phase acknowledge: rise after the push, fall once s_valid is seen low
  always_ff @(posedge clk) begin
    if (rst)            s_ready <= 1'b0;
    else if (wr_en)     s_ready <= 1'b1;
    else if (!s_valid)  s_ready <= 1'b0;
  end

  // remember the previous pushed address for contiguity detection
  always_ff @(posedge clk) begin
    if (rst) begin
      last_addr <= '0;
      have_last <= 1'b0;
    end else if (wr_en) begin
      last_addr <= s_addr;
      have_last <= 1'b1;
    end
  end

  // inactivity timer forcing out partial bursts
  always_ff @(posedge clk) begin
    if (rst)                  timer <= '0;
    else if (wr_en || empty)  timer <= '0;
    else if (timer != TMAX)   timer <= timer + 1'b1;
  end

  // flush request held until everything has drained; a new flush wins
  always_ff @(posedge clk) begin
    if (rst)        flush_pending <= 1'b0;
    else if (flush) flush_pending <= 1'b1;
    else if (idle)  flush_pending <= 1'b0;
  end

  // sticky error flag; the handshake gating should keep this at zero
  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
  end

  // the burst can extend while the next entry exists, is contiguous and fits
  assign scan_grow = (scan_len < count) && (scan_len < BMAX) && scan_cont;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:
        if (count >= BMAX ||
            (count != '0 && (timer == TMAX || flush_pending))) state_nx = ST_SCAN;
      ST_SCAN:      if (!scan_grow)               state_nx = ST_REQ;
      ST_REQ:       if (m_gnt)                    state_nx = ST_DATA;
      ST_DATA:      if (pop && rem == 1)          state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: if (m_done)                   state_nx = ST_IDLE;
      default:                                    state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs: request strobe and pop gating (extra data requests ignored)
  always_comb begin
    m_req = (state == ST_REQ);
    pop   = (state == ST_DATA) && m_data_req && (rem != '0);
  end

  // burst bookkeeping: scan length, latched address/length, words remaining
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_len <= '0;
      m_addr   <= '0;
      m_len    <= '0;
      rem      <= '0;
    end else begin
      case (state)
        ST_IDLE: scan_len <= (FIFO_AW+1)'(1);
        ST_SCAN:
          if (scan_grow) scan_len <= scan_len + 1'b1;
          else begin
            m_addr <= head_addr;
            m_len  <= scan_len;
          end
        ST_REQ:  if (m_gnt) rem <= m_len;
        ST_DATA: if (pop)   rem <= rem - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_pixel_write_combiner.sv
// Directed bench: table of push patterns with expected bursts, plus hand-written
// sequences for FIFO stall, four-phase timing and reset mid-burst.
module tb_sdram_pixel_write_combiner;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_ready, flush, idle, m_req, m_gnt;
  logic        m_data_req, m_done, overflow;
  logic [23:0] s_addr, m_addr;
  logic [15:0] s_data, m_data;
  logic [4:0]  m_len;

  int checks = 0;
  int fails  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] dcnt = 16'h0ABC;

  sdram_pixel_write_combiner dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_addr(s_addr), .s_data(s_data), .flush(flush), .idle(idle),
    .m_req(m_req), .m_gnt(m_gnt), .m_addr(m_addr), .m_len(m_len),
    .m_data_req(m_data_req), .m_data(m_data), .m_done(m_done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [7:0][23:0] addrs;
    bit               fl;
    int               nb;
    logic [3:0][23:0] baddr;
    logic [3:0][4:0]  blen;
  } case_t;

  case_t tc[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // one four-phase handshake; hold = cycles s_valid stays up after s_ready
  task automatic push(input logic [23:0] a, input int hold);
    int t;
    s_addr = a; s_data = dcnt; s_valid = 1'b1;
    t = 0;
    do begin tick(); t++; end while (!s_ready && t < 400);
    chk("push_ack", {31'd0, s_ready}, 32'd1);
    exp_q.push_back(dcnt);
    dcnt++;
    repeat (hold) begin
      tick();
      chk("s_ready_hold", {31'd0, s_ready}, 32'd1);
    end
    s_valid = 1'b0;
    tick();
    chk("s_ready_fall", {31'd0, s_ready}, 32'd0);
  endtask

  task automatic pulse_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int t = 0;
    while (!m_req && t < 300) begin tick(); t++; end
    chk("m_req_seen", {31'd0, m_req}, 32'd1);
    ok = m_req;
  endtask

  task automatic pull_word();
    m_data_req = 1'b1;
    if (exp_q.size() == 0) begin
      checks++; fails++;
      $display("FAIL extra_word actual=%h required=none", m_data);
    end else chk("m_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
    tick();
    m_data_req = 1'b0;
  endtask

  // controller model: grant, pull m_len words, one spare pull, then done
  task automatic serve(input logic [23:0] ea, input logic [4:0] el);
    bit ok;
    wait_req(ok);
    if (!ok) return;
    chk("m_addr", {8'd0, m_addr}, {8'd0, ea});
    chk("m_len", {27'd0, m_len}, {27'd0, el});
    m_gnt = 1'b1; tick(); m_gnt = 1'b0;
    for (int i = 0; i < int'(el); i++) pull_word();
    m_data_req = 1'b1; tick(); m_data_req = 1'b0;
    chk("m_req_after", {31'd0, m_req}, 32'd0);
    m_done = 1'b1; tick(); m_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 8; i++) tc[0].addrs[i] = 24'(i);
    tc[0].n = 8; tc[0].fl = 0; tc[0].nb = 1;
    tc[0].baddr[0] = 24'h0; tc[0].blen[0] = 5'd8;

    tc[1].n = 2; tc[1].addrs[0] = 24'h5; tc[1].addrs[1] = 24'h9; tc[1].fl = 0;
    tc[1].nb = 2; tc[1].baddr[0] = 24'h5; tc[1].blen[0] = 5'd1;
    tc[1].baddr[1] = 24'h9; tc[1].blen[1] = 5'd1;

    tc[2].n = 4; tc[2].addrs[0] = 24'hFE; tc[2].addrs[1] = 24'hFF;
    tc[2].addrs[2] = 24'h100; tc[2].addrs[3] = 24'h101; tc[2].fl = 1;
    tc[2].nb = 2; tc[2].baddr[0] = 24'hFE; tc[2].blen[0] = 5'd2;
    tc[2].baddr[1] = 24'h100; tc[2].blen[1] = 5'd2;

    tc[3].n = 3; tc[3].addrs[0] = 24'h10; tc[3].addrs[1] = 24'h11;
    tc[3].addrs[2] = 24'h13; tc[3].fl = 1;
    tc[3].nb = 2; tc[3].baddr[0] = 24'h10; tc[3].blen[0] = 5'd2;
    tc[3].baddr[1] = 24'h13; tc[3].blen[1] = 5'd1;

    tc[4].n = 3; tc[4].addrs[0] = 24'hFFFFFE; tc[4].addrs[1] = 24'hFFFFFF;
    tc[4].addrs[2] = 24'h000000; tc[4].fl = 1;
    tc[4].nb = 2; tc[4].baddr[0] = 24'hFFFFFE; tc[4].blen[0] = 5'd2;
    tc[4].baddr[1] = 24'h000000; tc[4].blen[1] = 5'd1;

    rst = 1'b1; s_valid = 0; s_addr = 0; s_data = 0; flush = 0;
    m_gnt = 0; m_data_req = 0; m_done = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_m_req", {31'd0, m_req}, 32'd0);
    chk("rst_m_addr", {8'd0, m_addr}, 32'd0);
    chk("rst_m_len", {27'd0, m_len}, 32'd0);
    chk("rst_m_data", {16'd0, m_data}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    // table-driven burst formation
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < tc[k].n; i++) push(tc[k].addrs[i], 0);
      if (tc[k].fl) pulse_flush();
      else if (tc[k].n < 8) begin
        repeat (50) tick();
        chk("no_early_burst", {31'd0, m_req}, 32'd0);
      end
      for (int b = 0; b < tc[k].nb; b++) serve(tc[k].baddr[b], tc[k].blen[b]);
      tick();
      chk("idle_after", {31'd0, idle}, 32'd1);
      chk("queue_empty", exp_q.size(), 32'd0);
    end

    // FIFO full stall with the grant withheld, then drain 8/8/4
    for (int i = 0; i < 16; i++) push(24'h200 + 24'(i), 0);
    fork
      begin
        for (int i = 16; i < 20; i++) push(24'h200 + 24'(i), 0);
      end
      begin
        repeat (10) tick();
        chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
        chk("stall_overflow", {31'd0, overflow}, 32'd0);
        serve(24'h200, 5'd8);
        serve(24'h208, 5'd8);
      end
    join
    pulse_flush();
    serve(24'h210, 5'd4);
    tick();
    chk("drain_idle", {31'd0, idle}, 32'd1);
    chk("drain_overflow", {31'd0, overflow}, 32'd0);

    // four-phase spacing: quick drop with 4-cycle gaps, and a long hold
    for (int i = 0; i < 3; i++) begin
      push(24'h400 + 24'(i), 0);
      repeat (4) tick();
    end
    push(24'h403, 3);
    pulse_flush();
    serve(24'h400, 5'd4);
    tick();
    chk("fourphase_idle", {31'd0, idle}, 32'd1);
    chk("fourphase_queue", exp_q.size(), 32'd0);

    // reset in the middle of a burst
    begin
      bit ok;
      for (int i = 0; i < 8; i++) push(24'h600 + 24'(i), 0);
      wait_req(ok);
      m_gnt = 1'b1; tick(); m_gnt = 1'b0;
      for (int i = 0; i < 3; i++) pull_word();
      rst = 1'b1;
      tick();
      chk("midrst_idle", {31'd0, idle}, 32'd1);
      chk("midrst_m_req", {31'd0, m_req}, 32'd0);
      chk("midrst_s_ready", {31'd0, s_ready}, 32'd0);
      chk("midrst_m_len", {27'd0, m_len}, 32'd0);
      chk("midrst_m_data", {16'd0, m_data}, 32'd0);
      rst = 1'b0;
      exp_q.delete();
      repeat (80) tick();
      chk("midrst_no_burst", {31'd0, m_req}, 32'd0);
      chk("midrst_still_idle", {31'd0, idle}, 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
